// File: rtl/sdram_burst_scheduler.sv
// Burst arbiter for the SDRAM frame buffer: picks refresh, urgent reads or round-robin
// among two camera write ports and two VGA read ports, and owns the per-port frame pointers.
module sdram_burst_scheduler #(
  parameter int ADDR_W     = 23,
  parameter int LEN_W      = 9,
  parameter int USEDW_W    = 10,
  parameter int FIFO_DEPTH = 512,
  parameter int BURST_LEN  = 80,
  parameter int URGENT_WM  = 64,
  parameter int WR1_BASE   = 32'd0,
  parameter int WR1_MAX    = 32'd307200,
  parameter int WR2_BASE   = 32'h0010_0000,
  parameter int WR2_MAX    = 32'h0010_0000 + 32'd307200,
  parameter int RD1_BASE   = 32'd0,
  parameter int RD1_MAX    = 32'd307200,
  parameter int RD2_BASE   = 32'h0010_0000,
  parameter int RD2_MAX    = 32'h0010_0000 + 32'd307200
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iLOAD,
  input  logic               iRD_EN,
  input  logic [USEDW_W-1:0] iWR1_USEDW,
  input  logic [USEDW_W-1:0] iWR2_USEDW,
  input  logic [USEDW_W-1:0] iRD1_USEDW,
  input  logic [USEDW_W-1:0] iRD2_USEDW,
  input  logic               iREF_REQ,
  output logic               oCMD_VALID,
  output logic [1:0]         oCMD_OP,
  output logic [1:0]         oCMD_PORT,
  output logic [ADDR_W-1:0]  oCMD_ADDR,
  output logic [LEN_W-1:0]   oCMD_LEN,
  input  logic               iCMD_READY,
  input  logic               iCMD_DONE,
  output logic               oBUSY
);

  localparam int AW1 = ADDR_W + 1;
  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_REF = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10
  } state_t;

  function automatic logic [ADDR_W-1:0] base_of(input logic [1:0] p);
    case (p)
      2'd0:    base_of = ADDR_W'(WR1_BASE);
      2'd1:    base_of = ADDR_W'(WR2_BASE);
      2'd2:    base_of = ADDR_W'(RD1_BASE);
      default: base_of = ADDR_W'(RD2_BASE);
    endcase
  endfunction

  function automatic logic [AW1-1:0] max_of(input logic [1:0] p);
    case (p)
      2'd0:    max_of = AW1'(WR1_MAX);
      2'd1:    max_of = AW1'(WR2_MAX);
      2'd2:    max_of = AW1'(RD1_MAX);
      default: max_of = AW1'(RD2_MAX);
    endcase
  endfunction

  // One extra bit of headroom so ptr + BURST_LEN can never wrap before the MAX compare.
  function automatic logic [ADDR_W-1:0] advance(input logic [1:0] p, input logic [ADDR_W-1:0] ptr);
    logic [AW1-1:0] sum;
    logic [AW1-1:0] nxt;
    sum = {1'b0, ptr} + AW1'(BURST_LEN);
    if (sum >= max_of(p)) begin
      nxt = {1'b0, base_of(p)};
    end else begin
      nxt = sum;
    end
    return nxt[ADDR_W-1:0];
  endfunction

  state_t            state_q, state_d;
  logic              valid_q, valid_d;
  logic [1:0]        op_q, op_d;
  logic [1:0]        port_q, port_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              busy_q, busy_d;
  logic [1:0]        last_q, last_d;
  logic [ADDR_W-1:0] ptr_q [4];
  logic [ADDR_W-1:0] ptr_d [4];

  logic [3:0] req_s;
  logic [1:0] urg_s;
  logic [3:0] rot_s;
  logic [1:0] off_s;
  logic       win_any_s;
  logic       win_rr_s;
  logic [1:0] win_port_s;
  logic [1:0] win_op_s;

  assign req_s[0] = (32'(iWR1_USEDW) >= 32'(BURST_LEN));
  assign req_s[1] = (32'(iWR2_USEDW) >= 32'(BURST_LEN));
  assign req_s[2] = iRD_EN && (32'(iRD1_USEDW) + 32'(BURST_LEN) <= 32'(FIFO_DEPTH));
  assign req_s[3] = iRD_EN && (32'(iRD2_USEDW) + 32'(BURST_LEN) <= 32'(FIFO_DEPTH));
  assign urg_s[0] = req_s[2] && (32'(iRD1_USEDW) < 32'(URGENT_WM));
  assign urg_s[1] = req_s[3] && (32'(iRD2_USEDW) < 32'(URGENT_WM));

  // Winner selection: refresh, then urgent reads, then round-robin after the last RR grant.
  always_comb begin
    rot_s      = 4'(({req_s, req_s}) >> (last_q + 2'd1));
    off_s      = 2'd0;
    win_any_s  = 1'b0;
    win_rr_s   = 1'b0;
    win_port_s = 2'd0;
    win_op_s   = OP_WR;
    casez (rot_s)
      4'b???1: off_s = 2'd0;
      4'b??10: off_s = 2'd1;
      4'b?100: off_s = 2'd2;
      4'b1000: off_s = 2'd3;
      default: off_s = 2'd0;
    endcase
    if (iREF_REQ) begin
      win_any_s = 1'b1;
      win_op_s  = OP_REF;
    end else if (urg_s[0]) begin
      win_any_s  = 1'b1;
      win_port_s = 2'd2;
      win_op_s   = OP_RD;
    end else if (urg_s[1]) begin
      win_any_s  = 1'b1;
      win_port_s = 2'd3;
      win_op_s   = OP_RD;
    end else begin
      win_any_s  = |req_s;
      win_rr_s   = |req_s;
      win_port_s = last_q + 2'd1 + off_s;
      win_op_s   = win_port_s[1] ? OP_RD : OP_WR;
    end
  end

  // Next-state, command registers and pointer update.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    op_d    = op_q;
    port_d  = port_q;
    addr_d  = addr_q;
    len_d   = len_q;
    busy_d  = busy_q;
    last_d  = last_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (!iLOAD && win_any_s) begin
          state_d = S_ISSUE;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          op_d    = win_op_s;
          port_d  = win_port_s;
          addr_d  = (win_op_s == OP_REF) ? {ADDR_W{1'b0}} : ptr_q[win_port_s];
          len_d   = (win_op_s == OP_REF) ? {LEN_W{1'b0}} : LEN_W'(BURST_LEN);
          last_d  = win_rr_s ? win_port_s : last_q;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (iCMD_READY) begin
          state_d = S_WAIT;
          valid_d = 1'b0;
          if (op_q != OP_REF) begin
            ptr_d[port_q] = advance(port_q, ptr_q[port_q]);
          end else begin
            ptr_d[port_q] = ptr_q[port_q];
          end
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT: begin
        if (iCMD_DONE) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
    // Reload wins over a same-cycle advance.
    for (int k = 0; k < 4; k++) begin
      ptr_d[k] = iLOAD ? base_of(2'(k)) : ptr_d[k];
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      op_q    <= 2'b00;
      port_q  <= 2'd0;
      addr_q  <= {ADDR_W{1'b0}};
      len_q   <= {LEN_W{1'b0}};
      busy_q  <= 1'b0;
      last_q  <= 2'd3;
      for (int k = 0; k < 4; k++) begin
        ptr_q[k] <= base_of(2'(k));
      end
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      op_q    <= op_d;
      port_q  <= port_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      ptr_q   <= ptr_d;
    end
  end

  assign oCMD_VALID = valid_q;
  assign oCMD_OP    = op_q;
  assign oCMD_PORT  = port_q;
  assign oCMD_ADDR  = addr_q;
  assign oCMD_LEN   = len_q;
  assign oBUSY      = busy_q;

endmodule

// File: tb/tb_sdram_burst_scheduler.sv
// Randomized and directed bench for sdram_burst_scheduler against a grant/pointer model.
module tb_sdram_burst_scheduler;

  logic        clk = 1'b0;
  logic        rst, load, rd_en, ref_req, ready, done;
  logic [9:0]  wr1, wr2, rd1, rd2;
  logic        ovalid, obusy;
  logic [1:0]  oop, oport;
  logic [22:0] oaddr;
  logic [8:0]  olen;

  int n_checks = 0;
  int n_pass   = 0;
  int ptr_m [4];
  int last_m;
  logic [22:0] a;
  logic [1:0]  p;

  sdram_burst_scheduler dut (
    .iCLK(clk), .iRST(rst), .iLOAD(load), .iRD_EN(rd_en),
    .iWR1_USEDW(wr1), .iWR2_USEDW(wr2), .iRD1_USEDW(rd1), .iRD2_USEDW(rd2),
    .iREF_REQ(ref_req), .oCMD_VALID(ovalid), .oCMD_OP(oop), .oCMD_PORT(oport),
    .oCMD_ADDR(oaddr), .oCMD_LEN(olen), .iCMD_READY(ready), .iCMD_DONE(done),
    .oBUSY(obusy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int base_m(input int port);
    return (port % 2 == 0) ? 0 : 32'h100000;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) ptr_m[k] = base_m(k);
    last_m = 3;
  endtask

  // Reference arbitration computed from the priority rules.
  task automatic pick(output int op, output int port, output bit any, output bit rr);
    bit req [4];
    req[0] = (int'(wr1) >= 80);
    req[1] = (int'(wr2) >= 80);
    req[2] = rd_en && (512 - int'(rd1) >= 80);
    req[3] = rd_en && (512 - int'(rd2) >= 80);
    any = 1'b0; rr = 1'b0; op = 0; port = 0;
    if (ref_req) begin
      any = 1'b1; op = 2;
    end else if (req[2] && int'(rd1) < 64) begin
      any = 1'b1; op = 1; port = 2;
    end else if (req[3] && int'(rd2) < 64) begin
      any = 1'b1; op = 1; port = 3;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (last_m + k) % 4;
        if (!any && req[c]) begin
          any = 1'b1; rr = 1'b1; port = c; op = (c >= 2) ? 1 : 0;
        end
      end
    end
  endtask

  task automatic rand_inputs();
    wr1   = 10'($urandom_range(0, 160));
    wr2   = 10'($urandom_range(0, 160));
    rd1   = 10'($urandom_range(0, 520));
    rd2   = 10'($urandom_range(0, 520));
    rd_en = ($urandom_range(0, 3) != 0);
    if (!ref_req) ref_req = ($urandom_range(0, 7) == 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // mode 0: immediate ready/done; 1: ready held 5 cycles; 2: random delays, input churn, reload
  task automatic run_txn(input int mode, input bit rst_wait, output logic [22:0] oa, output logic [1:0] op_port);
    int op, port, hold, gap, eaddr, nxt;
    bit any, rr, ld;
    pick(op, port, any, rr);
    @(posedge clk); #1;
    oa = oaddr;
    op_port = oport;
    if (!any) begin
      check_eq("no_grant_valid", 32'(ovalid), 32'd0);
      return;
    end
    if (rr) last_m = port;
    eaddr = (op == 2) ? 0 : ptr_m[port];
    check_eq("grant_valid", 32'(ovalid), 32'd1);
    check_eq("grant_op", 32'(oop), 32'(op));
    check_eq("grant_port", 32'(oport), 32'(port));
    check_eq("grant_addr", 32'(oaddr), 32'(eaddr));
    check_eq("grant_len", 32'(olen), (op == 2) ? 32'd0 : 32'd80);
    check_eq("grant_busy", 32'(obusy), 32'd1);
    hold = (mode == 0) ? 0 : (mode == 1) ? 5 : $urandom_range(0, 5);
    repeat (hold) begin
      if (mode == 2) begin
        wr1 = 10'($urandom_range(0, 160)); rd2 = 10'($urandom_range(0, 520));
        rd_en = ~rd_en;
      end
      @(posedge clk); #1;
      check_eq("hold_valid", 32'(ovalid), 32'd1);
      check_eq("hold_op", 32'(oop), 32'(op));
      check_eq("hold_port", 32'(oport), 32'(port));
      check_eq("hold_addr", 32'(oaddr), 32'(eaddr));
      check_eq("hold_len", 32'(olen), (op == 2) ? 32'd0 : 32'd80);
    end
    ld = (mode == 2) && ($urandom_range(0, 9) == 0);
    ready = 1'b1; load = ld;
    @(posedge clk); #1;
    ready = 1'b0; load = 1'b0;
    check_eq("accept_valid", 32'(ovalid), 32'd0);
    check_eq("accept_busy", 32'(obusy), 32'd1);
    if (op == 2) begin
      ref_req = 1'b0;
    end else begin
      nxt = ptr_m[port] + 80;
      ptr_m[port] = (nxt >= base_m(port) + 307200) ? base_m(port) : nxt;
    end
    if (ld) for (int k = 0; k < 4; k++) ptr_m[k] = base_m(k);
    if (rst_wait) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      check_eq("rst_valid", 32'(ovalid), 32'd0);
      check_eq("rst_op", 32'(oop), 32'd0);
      check_eq("rst_port", 32'(oport), 32'd0);
      check_eq("rst_addr", 32'(oaddr), 32'd0);
      check_eq("rst_len", 32'(olen), 32'd0);
      check_eq("rst_busy", 32'(obusy), 32'd0);
      return;
    end
    gap = (mode == 0) ? 0 : $urandom_range(0, 3);
    repeat (gap) begin
      @(posedge clk); #1;
      check_eq("wait_busy", 32'(obusy), 32'd1);
    end
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    check_eq("done_valid", 32'(ovalid), 32'd0);
    check_eq("done_busy", 32'(obusy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; rd_en = 1'b0; ref_req = 1'b0; ready = 1'b0; done = 1'b0;
    wr1 = 10'd0; wr2 = 10'd0; rd1 = 10'd0; rd2 = 10'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_eq("reset_valid", 32'(ovalid), 32'd0);
    check_eq("reset_op", 32'(oop), 32'd0);
    check_eq("reset_port", 32'(oport), 32'd0);
    check_eq("reset_addr", 32'(oaddr), 32'd0);
    check_eq("reset_len", 32'(olen), 32'd0);
    check_eq("reset_busy", 32'(obusy), 32'd0);

    // single WR1 requester: first burst at 0, next at 80
    wr1 = 10'd80;
    run_txn(1, 1'b0, a, p); check_eq("wr1_first_addr", 32'(a), 32'd0);
    run_txn(0, 1'b0, a, p); check_eq("wr1_second_addr", 32'(a), 32'd80);

    // all four requesting: WR1, WR2, RD1, RD2, WR1
    do_reset();
    wr1 = 10'd100; wr2 = 10'd100; rd1 = 10'd200; rd2 = 10'd200; rd_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run_txn(0, 1'b0, a, p);
      check_eq("rr_order", 32'(p), 32'(i % 4));
    end

    // refresh first, then round-robin resumes at WR1
    do_reset();
    ref_req = 1'b1;
    run_txn(0, 1'b0, a, p);
    run_txn(0, 1'b0, a, p); check_eq("after_ref_port", 32'(p), 32'd0);

    // urgent RD2 beats the round-robin choice of WR1
    do_reset();
    rd1 = 10'd600; rd2 = 10'd10;
    run_txn(0, 1'b0, a, p); check_eq("urgent_rd2", 32'(p), 32'd3);

    // full frame of WR1 bursts, then wrap to base
    do_reset();
    wr1 = 10'd80; wr2 = 10'd0; rd_en = 1'b0;
    for (int i = 0; i < 3840; i++) begin
      run_txn(0, 1'b0, a, p);
    end
    check_eq("wrap_last_addr", 32'(a), 32'd307120);
    run_txn(0, 1'b0, a, p); check_eq("wrap_first_addr", 32'(a), 32'd0);
    run_txn(0, 1'b0, a, p);
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    for (int k = 0; k < 4; k++) ptr_m[k] = base_m(k);
    check_eq("load_no_grant", 32'(ovalid), 32'd0);
    run_txn(0, 1'b0, a, p); check_eq("load_addr", 32'(a), 32'd0);

    // reset while waiting for DONE, then WR1 starts again from base
    run_txn(1, 1'b1, a, p);
    run_txn(0, 1'b0, a, p); check_eq("post_rst_addr", 32'(a), 32'd0);

    do_reset();
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      run_txn(2, 1'b0, a, p);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sdram_burst_scheduler.md
Name: sdram_burst_scheduler

Overview:
Schedules burst transactions on the shared SDRAM frame buffer between four FIFO ports and the refresh engine. The four ports are two camera write ports (WR1 = G-high/B, WR2 = G-low/R) and two VGA read ports (RD1, RD2). The block sits between the port FIFOs and the SDRAM command engine inside the frame-buffer controller. It decides which port gets the next burst and owns the per-port address pointers, including wrap at frame end.

Parameters:
ADDR_W, 23, SDRAM word-address width
LEN_W, 9, burst-length field width
USEDW_W, 10, FIFO used-words width
FIFO_DEPTH, 512, words per port FIFO
BURST_LEN, 80, words per burst (all ports)
URGENT_WM, 64, read FIFO level below which a read port is urgent
WR1_BASE / WR1_MAX, 0 / 307200, WR1 address window
WR2_BASE / WR2_MAX, 23'h100000 / 23'h100000+307200, WR2 address window
RD1_BASE / RD1_MAX, 0 / 307200, RD1 address window
RD2_BASE / RD2_MAX, 23'h100000 / 23'h100000+307200, RD2 address window

Ports:
iCLK  in  1  system clock (SDRAM controller clock)
iRST  in  1  synchronous active-high reset
iLOAD  in  1  reload all address pointers to their bases
iRD_EN  in  1  display active; read ports may request only when 1
iWR1_USEDW, iWR2_USEDW  in  USEDW_W  write FIFO fill levels
iRD1_USEDW, iRD2_USEDW  in  USEDW_W  read FIFO fill levels
iREF_REQ  in  1  refresh due (level, held until refresh accepted)
oCMD_VALID  out  1  command offered
oCMD_OP  out  2  00 write, 01 read, 10 refresh
oCMD_PORT  out  2  0=WR1 1=WR2 2=RD1 3=RD2 (0 for refresh)
oCMD_ADDR  out  ADDR_W  burst start address (0 for refresh)
oCMD_LEN  out  LEN_W  BURST_LEN (0 for refresh)
iCMD_READY  in  1  engine accepts command when high with oCMD_VALID
iCMD_DONE  in  1  one-cycle pulse: accepted command finished
oBUSY  out  1  high in ISSUE and WAIT_DONE

Behaviour:
- Reset values: oCMD_VALID=0, oCMD_OP=0, oCMD_PORT=0, oCMD_ADDR=0, oCMD_LEN=0, oBUSY=0. All pointers at their BASE. Round-robin last-granted = RD2, so WR1 has first priority.
- Request conditions:
  - write port n: USEDW >= BURST_LEN.
  - read port n: iRD_EN && (FIFO_DEPTH - USEDW) >= BURST_LEN.
  - urgent read: requesting && USEDW < URGENT_WM.
- FSM IDLE -> ISSUE -> WAIT_DONE -> IDLE.
- IDLE: if iLOAD=0 and any request exists, register the winner and go to ISSUE. oCMD_VALID rises the next cycle (1-cycle decision latency).
- Priority order: (1) iREF_REQ; (2) urgent reads, RD1 before RD2; (3) round-robin over all requesting ports, starting after the last granted port. Grants under rules 1 and 2 do not update the round-robin pointer.
- ISSUE: oCMD_* held stable while oCMD_VALID=1 and iCMD_READY=0. On VALID&&READY: drop VALID next cycle, go to WAIT_DONE, advance the granted port's pointer.
- WAIT_DONE: wait for iCMD_DONE, then return to IDLE. iCMD_DONE is ignored in any other state. The minimum gap between commands is 2 idle cycles after DONE (DONE cycle, then IDLE decision).
- Pointer advance: next = ptr + BURST_LEN; if next >= MAX then ptr = BASE, else ptr = next. The address arithmetic is ADDR_W+1 bits wide, so no overflow. Refresh does not touch pointers.
- iLOAD:
  - All pointers go to BASE on the next clock. This overrides an advance in the same cycle.
  - An in-flight command is not aborted.
  - No new grant is made while iLOAD=1.
- Inputs change during ISSUE: no re-arbitration. The registered grant stands.
- iRD_EN falls during a read burst: the burst completes normally.
- Reset in any state returns to IDLE with reset values on the next clock, regardless of READY/DONE.

Test Plan:
- Reset, then WR1_USEDW=80 with all others idle -> VALID one cycle after the request is seen: OP=00, PORT=0, ADDR=0, LEN=80. After READY and DONE, the next WR1 grant has ADDR=80.
- All four ports requesting, iRD_EN=1, read levels 200 -> grant order WR1, WR2, RD1, RD2, WR1 across successive bursts.
- iREF_REQ together with all ports requesting -> refresh granted first (OP=10, PORT=0, ADDR=0, LEN=0), then round-robin resumes at WR1.
- RD2_USEDW=10 (urgent) while WR1/WR2 request and the round-robin pointer favours WR1 -> RD2 granted first.
- Drive 3840 WR1 bursts -> the 3840th uses ADDR=307120 and the next uses ADDR=0. iLOAD pulsed mid-frame -> the next WR1 grant uses ADDR=0.
- iCMD_READY held low 5 cycles -> oCMD_* stable throughout. iRST asserted in WAIT_DONE -> outputs at reset values next cycle and pointers at BASE.
